// File: rtl/s_conditioner_pkg.sv
// Shared types and defaults for the s_conditioner input conditioner.
package s_conditioner_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      SETTLE_HIGH = 2'b01,
      STABLE_HIGH = 2'b11,
      SETTLE_LOW  = 2'b10
   } state_t;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/s_conditioner_sync_chain.sv
// Multi-flop synchroniser for one asynchronous level; latency STAGES edges.
// No backpressure: samples d every clk edge, q is the last stage.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= {r_q[STAGES-2:0], d};
      end
   end

   assign q = r_q[STAGES-1];

endmodule

// File: rtl/s_conditioner.sv
// Synchronise + debounce a raw switch level into a clean s with rise/fall strobes.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges; no backpressure, free-running.
module s_conditioner
   import s_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic s,
   output logic rise,
   output logic fall,
   output logic settling
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             w_synced;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_s;
   logic             w_s_nxt;
   logic             r_rise;
   logic             w_rise_nxt;
   logic             r_fall;
   logic             w_fall_nxt;
   logic             r_settling;
   logic             w_settling_nxt;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw),
      .q   (w_synced)
   );

   // A return to the old level is tested before the threshold, so it wins a tie.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_s_nxt     = r_s;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         STABLE_LOW: begin
            if (w_synced) begin
               w_state_nxt = SETTLE_HIGH;
               w_cnt_nxt   = CNT_ONE;
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         SETTLE_HIGH: begin
            if (!w_synced) begin
               w_state_nxt = STABLE_LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE_HIGH;
               w_cnt_nxt   = '0;
               w_s_nxt     = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!w_synced) begin
               w_state_nxt = SETTLE_LOW;
               w_cnt_nxt   = CNT_ONE;
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         SETTLE_LOW: begin
            if (w_synced) begin
               w_state_nxt = STABLE_HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = STABLE_LOW;
               w_cnt_nxt   = '0;
               w_s_nxt     = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = STABLE_LOW;
            w_cnt_nxt   = '0;
            w_s_nxt     = 1'b0;
         end
      endcase
   end

   assign w_settling_nxt = (w_state_nxt == SETTLE_HIGH) || (w_state_nxt == SETTLE_LOW);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= STABLE_LOW;
         r_cnt      <= '0;
         r_s        <= 1'b0;
         r_rise     <= 1'b0;
         r_fall     <= 1'b0;
         r_settling <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_s        <= w_s_nxt;
         r_rise     <= w_rise_nxt;
         r_fall     <= w_fall_nxt;
         r_settling <= w_settling_nxt;
      end
   end

   assign s        = r_s;
   assign rise     = r_rise;
   assign fall     = r_fall;
   assign settling = r_settling;

endmodule

// File: tb/tb_s_conditioner.sv
// Directed bench for s_conditioner: default instance plus a 3-stage / 8-cycle instance.
module tb_s_conditioner;

   logic clk;
   logic rst;
   logic raw0, raw1;
   logic s0, rise0, fall0, settling0;
   logic s1, rise1, fall1, settling1;

   int n_checks;
   int n_errors;

   s_conditioner u_dut0 (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw0),
      .s        (s0),
      .rise     (rise0),
      .fall     (fall0),
      .settling (settling0)
   );

   s_conditioner #(
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (8)
   ) u_dut1 (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw1),
      .s        (s1),
      .rise     (rise1),
      .fall     (fall1),
      .settling (settling1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change #1 after an edge, so the next posedge is the first to sample them.
   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check0(input string tag, input logic exp_s, input logic exp_rise,
                         input logic exp_fall, input logic exp_settling);
      check_eq({tag, ".s"},        32'(s0),        32'(exp_s));
      check_eq({tag, ".rise"},     32'(rise0),     32'(exp_rise));
      check_eq({tag, ".fall"},     32'(fall0),     32'(exp_fall));
      check_eq({tag, ".settling"}, 32'(settling0), 32'(exp_settling));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clk  = 1'b0;
      rst  = 1'b1;
      raw0 = 1'b1;
      raw1 = 1'b0;

      // Reset held with raw high: everything stays clear.
      repeat (3) edge_step();
      check0("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("rst_hold.s1", 32'(s1), 32'(0));

      // raw=1 at release: fresh rise, s/rise at edge 6, settling edges 3..5.
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         edge_step();
         check0($sformatf("rst_rel_e%0d", e), e >= 6, e == 6, 1'b0, (e >= 3) && (e <= 5));
      end

      // Release: fall one cycle at edge 6, s back to 0.
      raw0 = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         edge_step();
         check0($sformatf("release_e%0d", e), e < 6, 1'b0, e == 6, (e >= 3) && (e <= 5));
      end

      // Clean press held 10 cycles, then release and let it settle.
      raw0 = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         edge_step();
         check0($sformatf("press_e%0d", e), e >= 6, e == 6, 1'b0, (e >= 3) && (e <= 5));
      end
      raw0 = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         edge_step();
         check0($sformatf("press_rel_e%0d", e), e < 6, 1'b0, e == 6, (e >= 3) && (e <= 5));
      end

      // Glitch of 3 cycles: counter reaches 3 as synced returns to 0, return wins.
      for (int e = 1; e <= 10; e++) begin
         raw0 = (e <= 3);
         edge_step();
         check0($sformatf("glitch_e%0d", e), 1'b0, 1'b0, 1'b0, (e >= 3) && (e <= 5));
      end

      // Bounce 1,0,1,0,1 then hold 1: single rise 6 edges after the last 0->1 (edge 5).
      for (int e = 1; e <= 14; e++) begin
         raw0 = (e == 2 || e == 4) ? 1'b0 : 1'b1;
         edge_step();
         check_eq($sformatf("bounce_e%0d.s", e),    32'(s0),    32'(e >= 10));
         check_eq($sformatf("bounce_e%0d.rise", e), 32'(rise0), 32'(e == 10));
         check_eq($sformatf("bounce_e%0d.fall", e), 32'(fall0), 32'(0));
      end

      // Reset in the middle of SETTLE_LOW with s=1.
      raw0 = 1'b0;
      repeat (4) edge_step();
      check0("mid_settle_low", 1'b1, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      check0("mid_rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
      edge_step();
      rst = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         edge_step();
         check0($sformatf("post_rst_low_e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // 3-stage / 8-cycle instance: 7-cycle pulse rejected.
      for (int e = 1; e <= 16; e++) begin
         raw1 = (e <= 7);
         edge_step();
         check_eq($sformatf("p_glitch_e%0d.s", e),        32'(s1),        32'(0));
         check_eq($sformatf("p_glitch_e%0d.rise", e),     32'(rise1),     32'(0));
         check_eq($sformatf("p_glitch_e%0d.settling", e), 32'(settling1), 32'((e >= 4) && (e <= 10)));
      end

      // 3-stage / 8-cycle instance: rise latency of 11 edges.
      raw1 = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         edge_step();
         check_eq($sformatf("p_rise_e%0d.s", e),    32'(s1),    32'(e >= 11));
         check_eq($sformatf("p_rise_e%0d.rise", e), 32'(rise1), 32'(e == 11));
         check_eq($sformatf("p_rise_e%0d.fall", e), 32'(fall1), 32'(0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/s_conditioner.md
# s_conditioner

Input conditioner that sits directly upstream of the pulse FSM and drives its `s` input. It synchronises an asynchronous raw switch/button level into `clk`, debounces it, and presents a clean registered level plus one-cycle rise/fall strobes. Downstream logic can then treat `s` as glitch-free and metastability-safe.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal values ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles at a new level required before accepting it; legal values ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width (derived, not overridden).
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `raw`  in  1  asynchronous undebounced input level.
- `s`  out  1  clean debounced level; registered; feeds the pulse FSM `s`.
- `rise`  out  1  one-cycle strobe, high in the first cycle `s` is 1.
- `fall`  out  1  one-cycle strobe, high in the first cycle `s` is 0 after being 1.
- `settling`  out  1  high while a candidate level change is being qualified.

## Operation
- Synchroniser: a shift chain of `SYNC_STAGES` flops; `synced` is the last stage.
- FSM states:
  - STABLE_LOW (`s`=0)
  - SETTLE_HIGH (`s`=0)
  - STABLE_HIGH (`s`=1)
  - SETTLE_LOW (`s`=1)
- `cnt` counts consecutive cycles `synced` has held the candidate level, including the entry cycle.
- STABLE_LOW: if `synced`=1, go to SETTLE_HIGH with `cnt`=1; otherwise stay, `cnt`=0.
- SETTLE_HIGH:
  - `synced`=0: back to STABLE_LOW, `cnt`=0, no output change (glitch rejected).
  - `synced`=1 and `cnt`=`DEBOUNCE_CYCLES`-1: go to STABLE_HIGH, `s`←1, `rise`←1, `cnt`←0.
  - Otherwise: `cnt`+1.
- STABLE_HIGH and SETTLE_LOW mirror the above with levels inverted; the accepting transition sets `s`←0 and `fall`←1.
- `rise` and `fall` are registered and cleared on the following edge unless re-asserted. They are never both high; at most one is asserted per accepted transition.
- `settling` = state is SETTLE_HIGH or SETTLE_LOW (registered with the state).
- `cnt` never exceeds `DEBOUNCE_CYCLES`-1 and has no wrap-around path.

## Timing
- Reset values while `rst`=1 and after release: all sync flops 0, state STABLE_LOW, `cnt`=0, `s`=0, `rise`=0, `fall`=0, `settling`=0.
- Latency: counting the first rising edge that samples `raw`=1 as edge 1, `s` and `rise` go high after edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. Defaults give edge 6. Falling latency is identical.
- `settling` goes high after edge `SYNC_STAGES`+1 and low at the accepting edge.
- A `raw` pulse whose synchronised width is ≤ `DEBOUNCE_CYCLES`-1 cycles produces no change on `s`, `rise` or `fall`.
- Simultaneous return-to-old-level and counter-at-threshold in the same cycle: the return wins and the change is rejected.
- Reset asserted mid-settle or mid-stable: all outputs clear immediately (asynchronous). If `raw`=1 at reset release, it is qualified as a fresh rise with the full latency.

## Structure
- Shared package `s_conditioner_pkg`:
  - state enum (2-bit: STABLE_LOW=00, SETTLE_HIGH=01, STABLE_HIGH=11, SETTLE_LOW=10);
  - `SYNC_STAGES_DEF`;
  - `DEBOUNCE_CYCLES_DEF`.
- One sub-module, `sync_chain` (parameter `STAGES`; ports `clk`, `rst`, `d`, `q`), reused by other async inputs.
- FSM, counter and output registers live in the top module.

## Test plan
- Reset: hold `rst`=1 with `raw`=1 for 3 cycles → `s`=`rise`=`fall`=`settling`=0. After release, `s`=1 and `rise`=1 at edge 6 only.
- Clean press and release (defaults): `raw` 0→1 held 10 cycles → `rise` high one cycle at edge 6. Then `raw` 1→0 → `fall` high one cycle 6 edges later, and `s` returns to 0.
- Glitch rejection: `raw` high for 3 cycles, then low → `settling` high 3 cycles, `s` stays 0, no `rise`.
- Bounce: `raw` toggles 1,0,1,0,1 at 1-cycle spacing, then holds 1 → `s` rises exactly once, 6 edges after the final 0→1, with a single `rise`.
- Reset mid-operation: assert `rst` during SETTLE_LOW while `s`=1 → `s`=0 immediately with no `fall` strobe. Hold `raw`=0 after release → outputs stay 0.
- Parameter sweep `SYNC_STAGES`=3, `DEBOUNCE_CYCLES`=8 → rise latency of 11 edges. A 7-cycle pulse is rejected.
